modeselect: RTL and testbench

MODESELECT -- requirements
Module: modeselect

---
 rtl/modeselect_pkg.sv | 6 +
 rtl/modeselect_btn_edge.sv | 31 +++
 rtl/modeselect.sv | 61 ++++++
 tb/tb_modeselect.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/modeselect_pkg.sv
// modeselect_pkg: shared constants for the mode/limit selector
package modeselect_pkg;
    localparam int DIGITS_DEFAULT = 6;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'h9;
endpackage

// File: rtl/modeselect_btn_edge.sv
// btn_edge: two-flop button synchronizer with a registered rising-edge pulse
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    logic s1_q, s1_d, s2_q, s2_d, arm_q, arm_d, pulse_q, pulse_d;
    // shift the button through the chain; only arm once the button has been seen low
    always_comb begin
        s1_d    = btn;
        s2_d    = s1_q;
        arm_d   = arm_q | ~btn;
        pulse_d = s1_q & ~s2_q & arm_q;
    end
    // a button held through reset leaves the edge detector disarmed until it is released
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            pulse_q <= 1'b0;
            arm_q   <= ~btn;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            pulse_q <= pulse_d;
            arm_q   <= arm_d;
        end
    end
    assign pulse = pulse_q;
endmodule

// File: rtl/modeselect.sv
// modeselect: toggled carry/max modes and a BCD-clamped upper-limit register
module modeselect
    import modeselect_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DIGIT_W*DIGITS-1:0] cnt_in,
    input  logic                      carry_set,
    input  logic                      max_set,
    input  logic                      refresh_limits,
    output logic [DIGIT_W*DIGITS-1:0] max_out,
    output logic                      max_en,
    output logic                      carry_en
);
    localparam int W = DIGIT_W * DIGITS;
    logic         carry_pulse, max_pulse;
    logic [W-1:0] clamped, max_out_q, max_out_d;
    logic         max_en_q, max_en_d, carry_en_q, carry_en_d;
    btn_edge u_carry (
        .clk   (clk),
        .reset (reset),
        .btn   (carry_set),
        .pulse (carry_pulse)
    );
    btn_edge u_max (
        .clk   (clk),
        .reset (reset),
        .btn   (max_set),
        .pulse (max_pulse)
    );
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_clamp
            assign clamped[g*DIGIT_W +: DIGIT_W] =
                (cnt_in[g*DIGIT_W +: DIGIT_W] > BCD_MAX) ? BCD_MAX : cnt_in[g*DIGIT_W +: DIGIT_W];
        end
    endgenerate
    // toggle modes on press pulses; load the clamped limit while refresh is high
    always_comb begin
        carry_en_d = carry_en_q ^ carry_pulse;
        max_en_d   = max_en_q ^ max_pulse;
        max_out_d  = refresh_limits ? clamped : max_out_q;
    end
    // reset to modes off and the largest representable limit
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_en_q <= 1'b0;
            max_en_q   <= 1'b0;
            max_out_q  <= {DIGITS{BCD_MAX}};
        end else begin
            carry_en_q <= carry_en_d;
            max_en_q   <= max_en_d;
            max_out_q  <= max_out_d;
        end
    end
    assign max_out  = max_out_q;
    assign max_en   = max_en_q;
    assign carry_en = carry_en_q;
endmodule

// File: tb/tb_modeselect.sv
// tb_modeselect: table-driven limit vectors plus press sequences, scoreboard-checked
module tb_modeselect;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        carry_set = 1'b0;
    logic        max_set = 1'b0;
    logic        refresh_limits = 1'b0;
    logic [23:0] cnt_in = '0;
    logic [23:0] max_out;
    logic        max_en, carry_en;

    modeselect dut (
        .clk            (clk),
        .reset          (reset),
        .cnt_in         (cnt_in),
        .carry_set      (carry_set),
        .max_set        (max_set),
        .refresh_limits (refresh_limits),
        .max_out        (max_out),
        .max_en         (max_en),
        .carry_en       (carry_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] mo;
        logic        me;
        logic        ce;
        string       name;
    } exp_t;

    typedef struct {
        logic [23:0] cnt;
        int          cyc;
        logic [23:0] exp;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[6];
    int          applied = 0;
    int          miscompares = 0;
    logic [23:0] e_mo;
    logic        e_me, e_ce;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name);
        exp_t e;
        sb.push_back('{e_mo, e_me, e_ce, name});
        tick();
        e = sb.pop_front();
        applied++;
        if (max_out !== e.mo || max_en !== e.me || carry_en !== e.ce) begin
            miscompares++;
            $display("FAIL %s: got max_out=%h max_en=%b carry_en=%b, expected max_out=%h max_en=%b carry_en=%b",
                     e.name, max_out, max_en, carry_en, e.mo, e.me, e.ce);
        end
    endtask

    task automatic press(input bit c, input bit m, input int hold, input string name);
        max_set = m;
        #1;
        carry_set = c;
        for (int k = 1; k <= hold; k++) begin
            if (k == 3) begin
                if (c) e_ce = ~e_ce;
                if (m) e_me = ~e_me;
            end
            step(name);
        end
        carry_set = 1'b0;
        max_set = 1'b0;
        for (int k = 0; k < 3; k++) step({name, "_release"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vt[0] = '{24'h123456, 5, 24'h123456};
        vt[1] = '{24'h004300, 1, 24'h004300};
        vt[2] = '{24'h00A0F3, 1, 24'h009093};
        vt[3] = '{24'hFFFFFF, 1, 24'h999999};
        vt[4] = '{24'hA0B0C0, 2, 24'h909090};
        vt[5] = '{24'h000000, 1, 24'h000000};
        e_mo = 24'h999999;
        e_me = 1'b0;
        e_ce = 1'b0;
        cnt_in = 24'h123456;
        refresh_limits = 1'b1;
        tick();
        step("reset_over_refresh");
        reset = 1'b0;
        refresh_limits = 1'b0;
        step("after_reset");
        press(1'b1, 1'b0, 10, "carry_hold");
        press(1'b0, 1'b1, 4, "max_first");
        press(1'b1, 1'b1, 5, "both_press");
        for (int i = 0; i < 6; i++) begin
            cnt_in = vt[i].cnt;
            refresh_limits = 1'b1;
            e_mo = vt[i].exp;
            for (int k = 0; k < vt[i].cyc; k++) step($sformatf("vec%0d_load", i));
            refresh_limits = 1'b0;
            cnt_in = 24'h777777;
            step($sformatf("vec%0d_hold", i));
            step($sformatf("vec%0d_hold", i));
        end
        refresh_limits = 1'b1;
        cnt_in = 24'h204302;
        e_mo = 24'h204302;
        step("level_first");
        cnt_in = 24'h020002;
        e_mo = 24'h020002;
        step("level_second");
        refresh_limits = 1'b0;
        cnt_in = 24'h111111;
        step("level_retain");
        step("level_retain");
        cnt_in = 24'h000001;
        refresh_limits = 1'b1;
        e_mo = 24'h000001;
        press(1'b1, 1'b1, 4, "press_with_refresh");
        refresh_limits = 1'b0;
        carry_set = 1'b1;
        reset = 1'b1;
        refresh_limits = 1'b1;
        cnt_in = 24'h123456;
        e_mo = 24'h999999;
        e_me = 1'b0;
        e_ce = 1'b0;
        step("reset_override");
        step("reset_override");
        reset = 1'b0;
        refresh_limits = 1'b0;
        for (int k = 0; k < 6; k++) step("held_through_reset");
        carry_set = 1'b0;
        for (int k = 0; k < 3; k++) step("released_after_reset");
        press(1'b1, 1'b0, 4, "repress");
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
